// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scan driver: digit count, field widths,
// segment bit positions and the hex-to-segment table.
package seg_pkg;

    localparam int unsigned DIGITS = 4;
    localparam int unsigned IDX_W  = 2;
    localparam int unsigned NIB_W  = 4;
    localparam int unsigned SEG_W  = 7;
    localparam int unsigned DISP_W = 8;
    localparam int unsigned VAL_W  = 16;

    localparam int unsigned SEG_A  = 0;
    localparam int unsigned SEG_B  = 1;
    localparam int unsigned SEG_C  = 2;
    localparam int unsigned SEG_D  = 3;
    localparam int unsigned SEG_E  = 4;
    localparam int unsigned SEG_F  = 5;
    localparam int unsigned SEG_G  = 6;
    localparam int unsigned SEG_DP = 7;

    // Active-high segments, bit0 = a .. bit6 = g; entry n is the glyph for hex digit n.
    localparam logic [15:0][SEG_W-1:0] HEX7_TABLE = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    // One-hot digit enable for a digit index.
    function automatic logic [DIGITS-1:0] digit_onehot(input logic [IDX_W-1:0] idx);
        return DIGITS'(1) << idx;
    endfunction

endpackage

// File: rtl/seg_scan_driver_if.sv
// Display-value and pin bundle between the CPU top level (master) and the scan driver (slave).
interface seg_scan_driver_if;
    import seg_pkg::*;

    logic [VAL_W-1:0]  value_i;
    logic              value_valid_i;
    logic [DIGITS-1:0] dp_i;
    logic [DIGITS-1:0] bcd_choose;
    logic [DISP_W-1:0] bcd_display;
    logic              frame_done_o;

    modport master (
        output value_i, value_valid_i, dp_i,
        input  bcd_choose, bcd_display, frame_done_o
    );

    modport slave (
        input  value_i, value_valid_i, dp_i,
        output bcd_choose, bcd_display, frame_done_o
    );

endinterface

// File: rtl/seg_hex_decoder.sv
// Combinational hex nibble to seven-segment glyph lookup.
module seg_hex_decoder
    import seg_pkg::*;
(
    input  logic [NIB_W-1:0] nibble,
    output logic [SEG_W-1:0] segments_c
);

    // Table lookup; every nibble value has an entry.
    assign segments_c = HEX7_TABLE[nibble];

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed 4-digit seven-segment driver with frame-boundary snapshot
// and per-slot blanking window.
// Optional build macro: SEG_LZB_EN enables leading-zero blanking of digits 3..1.
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int unsigned SCAN_DIV  = 100000,
    parameter int unsigned BLANK_CYC = 16
)(
    input  logic             sysclk,
    input  logic             reset,
    seg_scan_driver_if.slave bus
);

    localparam int unsigned CNT_W   = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned CNT_MAX = SCAN_DIV - 1;

    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [IDX_W-1:0]  idx, idx_nxt;
    logic [VAL_W-1:0]  snap, snap_nxt;
    logic [DIGITS-1:0] choose_q, choose_nxt;
    logic [DISP_W-1:0] disp_q, disp_nxt;
    logic              frame_done_q, frame_done_nxt;

    logic              slot_end;
    logic              boundary;
    logic [NIB_W-1:0]  nib_sel;
    logic [SEG_W-1:0]  seg_c;
    logic              digit_on;
    logic              in_blank;

    // Slot counter, digit index and snapshot advance.
    always_comb begin
        slot_end       = (cnt == CNT_W'(CNT_MAX));
        boundary       = slot_end && (idx == IDX_W'(DIGITS - 1));
        cnt_nxt        = slot_end ? '0 : cnt + CNT_W'(1);
        idx_nxt        = slot_end ? idx + IDX_W'(1) : idx;
        snap_nxt       = (boundary && bus.value_valid_i) ? bus.value_i : snap;
        frame_done_nxt = boundary;
    end

    // Nibble of the upcoming state's snapshot for the upcoming digit.
    assign nib_sel = NIB_W'(snap_nxt >> {idx_nxt, 2'b00});

    seg_hex_decoder u_hex (
        .nibble     (nib_sel),
        .segments_c (seg_c)
    );

`ifdef SEG_LZB_EN
    // Digit k is suppressed when it and every more-significant nibble are zero.
    always_comb begin
        digit_on = 1'b1;
        case (idx_nxt)
            2'd3:    digit_on = (snap_nxt[15:12] != '0);
            2'd2:    digit_on = (snap_nxt[15:8]  != '0);
            2'd1:    digit_on = (snap_nxt[15:4]  != '0);
            default: digit_on = 1'b1;
        endcase
    end
`else
    assign digit_on = 1'b1;
`endif

    // Pin values for the upcoming state; dark during the blanking window.
    always_comb begin
        in_blank   = (cnt_nxt < CNT_W'(BLANK_CYC));
        choose_nxt = '0;
        disp_nxt   = '0;
        if (!in_blank && digit_on) begin
            choose_nxt               = digit_onehot(idx_nxt);
            disp_nxt[SEG_G:SEG_A]    = seg_c;
            disp_nxt[SEG_DP]         = bus.dp_i[idx_nxt];
        end
    end

    // State and output registers.
    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            cnt          <= '0;
            idx          <= '0;
            snap         <= '0;
            choose_q     <= '0;
            disp_q       <= '0;
            frame_done_q <= 1'b0;
        end else begin
            cnt          <= cnt_nxt;
            idx          <= idx_nxt;
            snap         <= snap_nxt;
            choose_q     <= choose_nxt;
            disp_q       <= disp_nxt;
            frame_done_q <= frame_done_nxt;
        end
    end

    assign bus.bcd_choose   = choose_q;
    assign bus.bcd_display  = disp_q;
    assign bus.frame_done_o = frame_done_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Self-checking bench for seg_scan_driver (SCAN_DIV=8, BLANK_CYC=2).
// Build with +define+SEG_LZB_EN to exercise leading-zero blanking.
module tb_seg_scan_driver;

    localparam int SD    = 8;
    localparam int BC    = 2;
    localparam int FRAME = 4 * SD;

    logic sysclk = 1'b0;
    logic reset  = 1'b1;

    seg_scan_driver_if bus();

    seg_scan_driver #(.SCAN_DIV(SD), .BLANK_CYC(BC)) dut (
        .sysclk (sysclk),
        .reset  (reset),
        .bus    (bus)
    );

    always #5 sysclk = ~sysclk;

    int checks = 0;
    int errors = 0;

    logic [6:0] hex_ref [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    // Reference model: cycles since reset, snapshot, and dp sampled at the last edge.
    int          m_t;
    logic [15:0] m_snap;
    logic [3:0]  m_dp;

    always @(posedge sysclk or posedge reset) begin
        if (reset) begin
            m_t    <= 0;
            m_snap <= '0;
            m_dp   <= '0;
        end else begin
            if ((m_t % FRAME) == FRAME - 1 && bus.value_valid_i)
                m_snap <= bus.value_i;
            m_t  <= m_t + 1;
            m_dp <= bus.dp_i;
        end
    end

    task automatic model_out(output logic [3:0] ch, output logic [7:0] di, output logic fd);
        int          c;
        int          d;
        logic [15:0] up;
        logic        show;
        c    = m_t % SD;
        d    = (m_t / SD) % 4;
        up   = m_snap >> (4 * d);
        ch   = '0;
        di   = '0;
        fd   = (m_t > 0) && ((m_t % FRAME) == 0);
        show = (c >= BC);
`ifdef SEG_LZB_EN
        if (d > 0 && up == 16'h0) show = 1'b0;
`endif
        if (show) begin
            ch = 4'(1 << d);
            di = {m_dp[d], hex_ref[up[3:0]]};
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0h required %0h (t=%0d)", name, act, exp, m_t);
        end
    endtask

    task automatic check_model();
        logic [3:0] ch;
        logic [7:0] di;
        logic       fd;
        model_out(ch, di, fd);
        check("model bcd_choose",   bus.bcd_choose,   ch);
        check("model bcd_display",  bus.bcd_display,  di);
        check("model frame_done_o", bus.frame_done_o, fd);
    endtask

    task automatic step();
        @(posedge sysclk);
        #1;
        check_model();
    endtask

    task automatic wait_phase(input int ph);
        int n;
        n = 0;
        while ((m_t % FRAME) != ph) begin
            if (n >= 2 * FRAME) begin
                check("wait_phase timeout", n, 0);
                return;
            end
            step();
            n++;
        end
    endtask

    task automatic expect_digit(input string name, input logic [3:0] ch, input logic [7:0] di);
        check({name, " choose"},  bus.bcd_choose,  ch);
        check({name, " display"}, bus.bcd_display, di);
    endtask

    typedef struct {
        logic [15:0] value;
        logic [3:0]  dp;
        logic [7:0]  d0;
        logic [7:0]  d1;
        logic [7:0]  d2;
        logic [7:0]  d3;
    } vec_t;

    vec_t vecs [7];

    initial begin
        #200000;
        $display("FAIL watchdog actual timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] ed;
        logic [3:0] ec;

        vecs[0] = '{16'h12AB, 4'b0000, 8'h7C, 8'h77, 8'h5B, 8'h06};
        vecs[1] = '{16'h3456, 4'b1010, 8'h7D, 8'hED, 8'h66, 8'hCF};
        vecs[2] = '{16'h789C, 4'b0001, 8'hB9, 8'h6F, 8'h7F, 8'h07};
        vecs[3] = '{16'hDEF0, 4'b0000, 8'h3F, 8'h71, 8'h79, 8'h5E};
`ifdef SEG_LZB_EN
        vecs[4] = '{16'h0005, 4'b0000, 8'h6D, 8'h00, 8'h00, 8'h00};
        vecs[5] = '{16'h0000, 4'b0000, 8'h3F, 8'h00, 8'h00, 8'h00};
        vecs[6] = '{16'h0E00, 4'b0000, 8'h3F, 8'h3F, 8'h79, 8'h00};
`else
        vecs[4] = '{16'h0005, 4'b0000, 8'h6D, 8'h3F, 8'h3F, 8'h3F};
        vecs[5] = '{16'h0000, 4'b0000, 8'h3F, 8'h3F, 8'h3F, 8'h3F};
        vecs[6] = '{16'h0E00, 4'b0000, 8'h3F, 8'h3F, 8'h79, 8'h3F};
`endif

        bus.value_i       = '0;
        bus.value_valid_i = 1'b0;
        bus.dp_i          = '0;

        // Reset state.
        #12;
        expect_digit("reset", 4'h0, 8'h00);
        check("reset frame_done", bus.frame_done_o, 0);
        @(negedge sysclk);
        reset = 1'b0;
        check_model();

        // Reset release: blanking, first frame 0000, first frame_done at cycle 32.
        bus.value_i       = 16'h12AB;
        bus.value_valid_i = 1'b1;
        for (int i = 1; i <= 34; i++) begin
            step();
            if (i == 1 || i == 8) check("rr blank choose", bus.bcd_choose, 4'h0);
            if (i == 2 || i == 7) expect_digit("rr digit0", 4'b0001, 8'h3F);
            check("rr frame_done", bus.frame_done_o, (i == 32));
        end

        // Frame 1 shows 12AB; switch to FFFF during digit 1.
        expect_digit("f1 d0", 4'b0001, 8'h7C);
        wait_phase(10);
        expect_digit("f1 d1", 4'b0010, 8'h77);
        bus.value_i = 16'hFFFF;
        wait_phase(18);
        expect_digit("f1 d2 mid", 4'b0100, 8'h5B);
        wait_phase(26);
        expect_digit("f1 d3 mid", 4'b1000, 8'h06);
        for (int k = 0; k < 4; k++) begin
            wait_phase(8 * k + 2);
            expect_digit("f2 ffff", 4'(1 << k), 8'h71);
        end

        // No capture without value_valid_i; frame_done still pulses.
        bus.value_valid_i = 1'b0;
        bus.value_i       = 16'h1234;
        wait_phase(0);
        check("hold frame_done", bus.frame_done_o, 1);
        for (int k = 0; k < 4; k++) begin
            wait_phase(8 * k + 2);
            expect_digit("hold", 4'(1 << k), 8'h71);
        end

        // Live decimal point on digit 2 only.
        bus.dp_i = 4'b0100;
        for (int k = 0; k < 4; k++) begin
            wait_phase(8 * k + 2);
            expect_digit("dp", 4'(1 << k), (k == 2) ? 8'hF1 : 8'h71);
        end

        // Asynchronous reset mid-slot at cnt = 5.
        wait_phase(5);
        expect_digit("pre-reset", 4'b0001, 8'h71);
        #2;
        reset = 1'b1;
        #1;
        expect_digit("async reset", 4'h0, 8'h00);
        check("async reset frame_done", bus.frame_done_o, 0);
        repeat (2) @(negedge sysclk);
        reset    = 1'b0;
        bus.dp_i = '0;
        check_model();

        // Table-driven captures and per-digit decode.
        for (int v = 0; v < 7; v++) begin
            bus.value_i       = vecs[v].value;
            bus.dp_i          = vecs[v].dp;
            bus.value_valid_i = 1'b1;
            wait_phase(FRAME - 1);
            step();
            for (int k = 0; k < 4; k++) begin
                wait_phase(8 * k + 2);
                case (k)
                    0:       ed = vecs[v].d0;
                    1:       ed = vecs[v].d1;
                    2:       ed = vecs[v].d2;
                    default: ed = vecs[v].d3;
                endcase
                ec = (ed != 8'h00) ? 4'(1 << k) : 4'h0;
                expect_digit("table", ec, ed);
            end
        end

        // Randomised stimulus against the model.
        for (int i = 0; i < 800; i++) begin
            bus.value_i       = 16'($urandom);
            bus.value_valid_i = ($urandom_range(0, 3) == 0);
            bus.dp_i          = 4'($urandom);
            if ($urandom_range(0, 5) == 0) bus.value_i = 16'($urandom_range(0, 255));
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
